// File: rtl/cs_pkg.sv
// cs_pkg: shared constants, block word type and FSM states for the block reader
package cs_pkg;
  localparam int BLK_DIM = 8;
  localparam int BLK_PIX = BLK_DIM * BLK_DIM;
  localparam int PIX_W_DEF = 8;
  typedef logic [BLK_PIX-1:0][PIX_W_DEF-1:0] blk_word_t;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;
endpackage

// File: rtl/cs_block_addr_gen.sv
// cs_block_addr_gen: block column/row and in-block pixel counters with raster ROM address
module cs_block_addr_gen
  import cs_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ADDR_W = 12
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clr,
  input  logic                                step,
  input  logic                                adv,
  output logic [5:0]                          k,
  output logic [$clog2(IMG_W/BLK_DIM)-1:0]    bx,
  output logic [$clog2(IMG_H/BLK_DIM)-1:0]    by,
  output logic [ADDR_W-1:0]                   addr,
  output logic                                last_pixel,
  output logic                                last_block
);
  localparam int XW = $clog2(IMG_W / BLK_DIM);
  localparam int YW = $clog2(IMG_H / BLK_DIM);
  logic last_x, last_y;
  assign last_x = bx == XW'(IMG_W / BLK_DIM - 1);
  assign last_y = by == YW'(IMG_H / BLK_DIM - 1);
  assign last_pixel = k == 6'(BLK_PIX - 1);
  assign last_block = last_x && last_y;
  assign addr = ADDR_W'({by, k[5:3]}) * ADDR_W'(IMG_W) + ADDR_W'({bx, k[2:0]});
  // pixel counter steps per read; block position advances in raster block order
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      k  <= '0;
      bx <= '0;
      by <= '0;
    end else begin
      if (step) k <= k + 6'd1;
      if (adv) begin
        bx <= last_x ? '0 : bx + XW'(1);
        if (last_x) by <= last_y ? '0 : by + YW'(1);
      end
    end
  end
endmodule

// File: rtl/cs_block_reader.sv
// cs_block_reader: reads an image ROM in 8x8 blocks and presents each as a 64-pixel word
// Optional ping-pong buffering enabled by defining CS_READER_DOUBLE_BUFFER_EN.
module cs_block_reader
  import cs_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = PIX_W_DEF,
  parameter int ADDR_W = 12
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [PIX_W-1:0]                   mem_rdata,
  output logic [BLK_PIX*PIX_W-1:0]           blk_pixels,
  output logic                               blk_valid,
  input  logic                               blk_ready,
  output logic [$clog2(IMG_W/BLK_DIM)-1:0]   blk_x,
  output logic [$clog2(IMG_H/BLK_DIM)-1:0]   blk_y,
  output logic                               busy,
  output logic                               done
);
  localparam int XW = $clog2(IMG_W / BLK_DIM);
  localparam int YW = $clog2(IMG_H / BLK_DIM);
  state_t state, nxt;
  logic [5:0] k, cap_k;
  logic [XW-1:0] bx;
  logic [YW-1:0] by;
  logic [ADDR_W-1:0] addr;
  logic last_pixel, last_block, adv, cap_en, hs;
  assign mem_rd_en = state == FETCH;
  assign mem_addr = mem_rd_en ? addr : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign hs = blk_valid && blk_ready;
  cs_block_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .reset(reset), .clr(state == DONE), .step(state == FETCH), .adv(adv),
    .k(k), .bx(bx), .by(by), .addr(addr), .last_pixel(last_pixel), .last_block(last_block)
  );
  // state register
  always_ff @(posedge clk) state <= !reset ? IDLE : nxt;
  // ROM data arrives a cycle after its read; remember which slot it belongs to
  always_ff @(posedge clk) begin
    cap_en <= reset && mem_rd_en;
    cap_k  <= reset ? k : '0;
  end
`ifdef CS_READER_DOUBLE_BUFFER_EN
  logic [BLK_PIX-1:0][PIX_W-1:0] bufs [2];
  logic [XW-1:0] px [2];
  logic [YW-1:0] py [2];
  logic [1:0] full;
  logic wb, rb, fin;
  assign adv = state == DRAIN;
  assign blk_valid = full[rb];
  assign blk_pixels = bufs[rb];
  assign blk_x = px[rb];
  assign blk_y = py[rb];
  // fetch side runs ahead into the free buffer; PRESENT waits for a free buffer or the last acceptance
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = last_pixel ? DRAIN : FETCH;
      DRAIN:   nxt = (last_block || full[~wb]) ? PRESENT : FETCH;
      PRESENT: nxt = fin ? ((hs && !full[~rb]) ? DONE : PRESENT) : (!full[wb] ? FETCH : PRESENT);
      default: nxt = IDLE;
    endcase
  end
  // ping-pong buffers: fill wb, present rb, tag each with its block position
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      fin <= 1'b0;
      bufs[0] <= '0;
      bufs[1] <= '0;
      px[0] <= '0;
      px[1] <= '0;
      py[0] <= '0;
      py[1] <= '0;
    end else begin
      if (cap_en) bufs[wb][cap_k] <= mem_rdata;
      if (state == DRAIN) begin
        full[wb] <= 1'b1;
        wb <= ~wb;
        px[wb] <= bx;
        py[wb] <= by;
        if (last_block) fin <= 1'b1;
      end
      if (hs) begin
        full[rb] <= 1'b0;
        rb <= ~rb;
      end
      if (state == DONE) fin <= 1'b0;
    end
  end
`else
  logic [BLK_PIX-1:0][PIX_W-1:0] pix;
  assign adv = hs;
  assign blk_valid = state == PRESENT;
  assign blk_pixels = pix;
  assign blk_x = bx;
  assign blk_y = by;
  // fetch a block, wait for pixel 63, then hold it until accepted
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = last_pixel ? DRAIN : FETCH;
      DRAIN:   nxt = PRESENT;
      PRESENT: nxt = blk_ready ? (last_block ? DONE : FETCH) : PRESENT;
      default: nxt = IDLE;
    endcase
  end
  // single block buffer, kept until overwritten or reset
  always_ff @(posedge clk) begin
    if (!reset) pix <= '0;
    else if (cap_en) pix[cap_k] <= mem_rdata;
  end
`endif
endmodule
